// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the load/store unit: op codes, bus widths, FSM states
// and the small decode helpers used by both the LSU and its lane extractor.
package mem_lsu_pkg;

  localparam logic RST_ENABLE   = 1'b1;
  localparam int   REG_BUS      = 32;
  localparam int   REG_ADDR_BUS = 5;

  localparam logic [7:0] OP_LB  = 8'hE0;
  localparam logic [7:0] OP_LH  = 8'hE1;
  localparam logic [7:0] OP_LW  = 8'hE3;
  localparam logic [7:0] OP_LBU = 8'hE4;
  localparam logic [7:0] OP_LHU = 8'hE5;
  localparam logic [7:0] OP_SB  = 8'hE8;
  localparam logic [7:0] OP_SH  = 8'hE9;
  localparam logic [7:0] OP_SW  = 8'hEB;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_e;

  function automatic logic is_load(input logic [7:0] op);
    return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
           (op == OP_LHU) || (op == OP_LW);
  endfunction

  function automatic logic is_store(input logic [7:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic is_misaligned(input logic [7:0] op, input logic [1:0] lo);
    logic bad;
    bad = 1'b0;
    case (op)
      OP_LH, OP_LHU, OP_SH: bad = lo[0];
      OP_LW, OP_SW:         bad = |lo;
      default:              bad = 1'b0;
    endcase
    return bad;
  endfunction

  // Lanes are big-endian: bit 3 of the select is the byte at offset 0.
  function automatic logic [3:0] lane_sel(input logic [7:0] op, input logic [1:0] lo);
    logic [3:0] sel;
    sel = 4'b0000;
    case (op)
      OP_LB, OP_LBU, OP_SB: sel = 4'b1000 >> lo;
      OP_LH, OP_LHU, OP_SH: sel = lo[1] ? 4'b0011 : 4'b1100;
      OP_LW, OP_SW:         sel = 4'b1111;
      default:              sel = 4'b0000;
    endcase
    return sel;
  endfunction

  function automatic logic [REG_BUS-1:0] store_data(input logic [7:0] op,
                                                    input logic [REG_BUS-1:0] d);
    logic [REG_BUS-1:0] w;
    case (op)
      OP_SB:   w = {4{d[7:0]}};
      OP_SH:   w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/mem_align.sv
// Picks the addressed byte/halfword out of a big-endian bus word and
// sign- or zero-extends it according to the load op.
module mem_align
  import mem_lsu_pkg::*;
(
  input  logic [7:0]         aluop,
  input  logic [1:0]         addr_lo,
  input  logic [REG_BUS-1:0] rdata,
  output logic [REG_BUS-1:0] result
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = 8'h00;
    case (addr_lo)
      2'd0:    byte_v = rdata[31:24];
      2'd1:    byte_v = rdata[23:16];
      2'd2:    byte_v = rdata[15:8];
      default: byte_v = rdata[7:0];
    endcase
    half_v = addr_lo[1] ? rdata[15:0] : rdata[31:16];

    result = '0;
    case (aluop)
      OP_LB:   result = {{24{byte_v[7]}}, byte_v};
      OP_LBU:  result = {24'h000000, byte_v};
      OP_LH:   result = {{16{half_v[15]}}, half_v};
      OP_LHU:  result = {16'h0000, half_v};
      OP_LW:   result = rdata;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: stalls the pipeline while a single bus transfer
// is in flight, aborts on a wait timeout and hands the result to mem_wb.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [REG_ADDR_BUS-1:0] mem_wd,
  input  logic                    mem_wreg,
  input  logic [REG_BUS-1:0]      mem_wdata,
  input  logic [7:0]              mem_aluop,
  input  logic [REG_BUS-1:0]      mem_addr,
  input  logic [REG_BUS-1:0]      mem_sdata,
  output logic                    d_req,
  output logic                    d_we,
  output logic [REG_BUS-1:0]      d_addr,
  output logic [3:0]              d_sel,
  output logic [REG_BUS-1:0]      d_wdata,
  input  logic [REG_BUS-1:0]      d_rdata,
  input  logic                    d_ack,
  output logic [REG_ADDR_BUS-1:0] wb_wd,
  output logic                    wb_wreg,
  output logic [REG_BUS-1:0]      wb_wdata,
  output logic                    stall_req,
  output logic                    exc_align,
  output logic                    exc_bus
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  lsu_state_e         state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               d_req_q, d_req_d;
  logic               d_we_q, d_we_d;
  logic [REG_BUS-1:0] d_addr_q, d_addr_d;
  logic [3:0]         d_sel_q, d_sel_d;
  logic [REG_BUS-1:0] d_wdata_q, d_wdata_d;
  logic [REG_BUS-1:0] ld_result_q, ld_result_d;
  logic               exc_bus_q, exc_bus_d;

  logic               op_load, op_store, op_mem, op_bad;
  logic [REG_BUS-1:0] align_result;

  assign op_load  = is_load(mem_aluop);
  assign op_store = is_store(mem_aluop);
  assign op_mem   = op_load || op_store;
  assign op_bad   = op_mem && is_misaligned(mem_aluop, mem_addr[1:0]);

  mem_align u_align (
    .aluop   (mem_aluop),
    .addr_lo (mem_addr[1:0]),
    .rdata   (d_rdata),
    .result  (align_result)
  );

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      d_req_q     <= 1'b0;
      d_we_q      <= 1'b0;
      d_addr_q    <= '0;
      d_sel_q     <= '0;
      d_wdata_q   <= '0;
      ld_result_q <= '0;
      exc_bus_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      d_req_q     <= d_req_d;
      d_we_q      <= d_we_d;
      d_addr_q    <= d_addr_d;
      d_sel_q     <= d_sel_d;
      d_wdata_q   <= d_wdata_d;
      ld_result_q <= ld_result_d;
      exc_bus_q   <= exc_bus_d;
    end
  end

  // Bus request and address/data are launched from registers so they stay
  // stable for the whole BUS phase; d_ack is only looked at in BUS.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    d_req_d     = d_req_q;
    d_we_d      = d_we_q;
    d_addr_d    = d_addr_q;
    d_sel_d     = d_sel_q;
    d_wdata_d   = d_wdata_q;
    ld_result_d = ld_result_q;
    exc_bus_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (op_mem && !op_bad) begin
          state_d   = ST_BUS;
          d_req_d   = 1'b1;
          d_we_d    = op_store;
          d_addr_d  = {mem_addr[REG_BUS-1:2], 2'b00};
          d_sel_d   = lane_sel(mem_aluop, mem_addr[1:0]);
          d_wdata_d = store_data(mem_aluop, mem_sdata);
        end
      end
      ST_BUS: begin
        if (d_ack) begin
          state_d = ST_DONE;
          d_req_d = 1'b0;
          d_we_d  = 1'b0;
          d_sel_d = '0;
          if (op_load) begin
            ld_result_d = align_result;
          end
        end else if (cnt_q + 8'd1 == TIMEOUT_CNT) begin
          state_d   = ST_DONE;
          cnt_d     = cnt_q + 8'd1;
          d_req_d   = 1'b0;
          d_we_d    = 1'b0;
          d_sel_d   = '0;
          exc_bus_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Writeback is suppressed while stalled, on misalignment, for stores and
  // after a bus timeout; reset forces every result output low.
  always_comb begin
    wb_wd     = mem_wd;
    wb_wreg   = mem_wreg;
    wb_wdata  = mem_wdata;
    stall_req = 1'b0;
    exc_align = 1'b0;
    exc_bus   = 1'b0;

    if (rst == RST_ENABLE) begin
      wb_wd    = '0;
      wb_wreg  = 1'b0;
      wb_wdata = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (op_bad) begin
            exc_align = 1'b1;
            wb_wreg   = 1'b0;
          end else if (op_mem) begin
            stall_req = 1'b1;
            wb_wreg   = 1'b0;
          end
        end
        ST_BUS: begin
          stall_req = 1'b1;
          wb_wreg   = 1'b0;
        end
        ST_DONE: begin
          exc_bus = exc_bus_q;
          if (op_load && !exc_bus_q) begin
            wb_wdata = ld_result_q;
          end else begin
            wb_wreg = 1'b0;
          end
        end
        default: begin
          wb_wreg = 1'b0;
        end
      endcase
    end
  end

  assign d_req   = d_req_q;
  assign d_we    = d_we_q;
  assign d_addr  = d_addr_q;
  assign d_sel   = d_sel_q;
  assign d_wdata = d_wdata_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed self-checking bench for mem_lsu (built with TIMEOUT = 4 so the
// bus-abort path is reachable in a few cycles).
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  localparam logic [7:0] OP_NOP = 8'h25;

  logic        clk;
  logic        rst;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic [7:0]  mem_aluop;
  logic [31:0] mem_addr;
  logic [31:0] mem_sdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [3:0]  d_sel;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;
  logic        stall_req;
  logic        exc_align;
  logic        exc_bus;

  int n_cmp;
  int n_fail;

  mem_lsu #(.TIMEOUT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_wd    (mem_wd),
    .mem_wreg  (mem_wreg),
    .mem_wdata (mem_wdata),
    .mem_aluop (mem_aluop),
    .mem_addr  (mem_addr),
    .mem_sdata (mem_sdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_sel     (d_sel),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_ack     (d_ack),
    .wb_wd     (wb_wd),
    .wb_wreg   (wb_wreg),
    .wb_wdata  (wb_wdata),
    .stall_req (stall_req),
    .exc_align (exc_align),
    .exc_bus   (exc_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [7:0] op, input logic [31:0] addr,
                                input logic [31:0] sdata, input logic [4:0] wd,
                                input logic wreg);
    mem_aluop = op;
    mem_addr  = addr;
    mem_sdata = sdata;
    mem_wd    = wd;
    mem_wreg  = wreg;
    mem_wdata = addr;
  endtask

  // Load acked in its first BUS cycle; checks the extended result in DONE.
  task automatic run_load(input string tag, input logic [7:0] op, input logic [31:0] addr,
                          input logic [31:0] rdata, input logic [31:0] exp);
    apply_stimulus(op, addr, 32'h0, 5'd9, 1'b1);
    #1;
    check_output({tag, "_stall"}, {31'b0, stall_req}, 32'd1);
    tick();
    d_ack   = 1'b1;
    d_rdata = rdata;
    #1;
    check_output({tag, "_dreq"}, {31'b0, d_req}, 32'd1);
    tick();
    d_ack   = 1'b0;
    d_rdata = 32'hA5A5A5A5;
    #1;
    check_output({tag, "_wdata"}, wb_wdata, exp);
    check_output({tag, "_wreg"}, {31'b0, wb_wreg}, 32'd1);
    tick();
    apply_stimulus(OP_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
  endtask

  initial begin
    n_cmp   = 0;
    n_fail  = 0;
    rst     = 1'b1;
    d_ack   = 1'b0;
    d_rdata = 32'h0;
    apply_stimulus(OP_NOP, 32'hDEADBEEF, 32'h0, 5'd17, 1'b1);
    tick();
    #1;
    check_output("rst_dreq", {31'b0, d_req}, 32'd0);
    check_output("rst_dsel", {28'b0, d_sel}, 32'd0);
    check_output("rst_wreg", {31'b0, wb_wreg}, 32'd0);
    check_output("rst_wdata", wb_wdata, 32'd0);
    check_output("rst_wd", {27'b0, wb_wd}, 32'd0);
    check_output("rst_stall", {31'b0, stall_req}, 32'd0);
    rst = 1'b0;
    tick();

    // Non-memory op passes straight through; stray d_ack in IDLE is ignored.
    apply_stimulus(OP_NOP, 32'h12345678, 32'h0, 5'd7, 1'b1);
    d_ack = 1'b1;
    #1;
    check_output("nm_wd", {27'b0, wb_wd}, 32'd7);
    check_output("nm_wreg", {31'b0, wb_wreg}, 32'd1);
    check_output("nm_wdata", wb_wdata, 32'h12345678);
    check_output("nm_stall", {31'b0, stall_req}, 32'd0);
    tick();
    d_ack = 1'b0;
    #1;
    check_output("idle_ack_dreq", {31'b0, d_req}, 32'd0);
    check_output("idle_ack_stall", {31'b0, stall_req}, 32'd0);

    // LW 0x100 acked in the second BUS cycle: stall spans three cycles.
    apply_stimulus(OP_LW, 32'h100, 32'h0, 5'd3, 1'b1);
    #1;
    check_output("lw_stall1", {31'b0, stall_req}, 32'd1);
    check_output("lw_idle_dreq", {31'b0, d_req}, 32'd0);
    check_output("lw_idle_wreg", {31'b0, wb_wreg}, 32'd0);
    tick();
    #1;
    check_output("lw_stall2", {31'b0, stall_req}, 32'd1);
    check_output("lw_dreq", {31'b0, d_req}, 32'd1);
    check_output("lw_dwe", {31'b0, d_we}, 32'd0);
    check_output("lw_daddr", d_addr, 32'h100);
    check_output("lw_dsel", {28'b0, d_sel}, 32'hF);
    tick();
    d_ack   = 1'b1;
    d_rdata = 32'h11223344;
    #1;
    check_output("lw_stall3", {31'b0, stall_req}, 32'd1);
    check_output("lw_dreq2", {31'b0, d_req}, 32'd1);
    tick();
    d_ack   = 1'b0;
    d_rdata = 32'h0;
    #1;
    check_output("lw_done_stall", {31'b0, stall_req}, 32'd0);
    check_output("lw_wdata", wb_wdata, 32'h11223344);
    check_output("lw_wreg", {31'b0, wb_wreg}, 32'd1);
    check_output("lw_wd", {27'b0, wb_wd}, 32'd3);
    check_output("lw_done_dreq", {31'b0, d_req}, 32'd0);
    tick();
    apply_stimulus(OP_NOP, 32'h0, 32'h0, 5'd0, 1'b0);

    run_load("lb", OP_LB, 32'h103, 32'h000000F0, 32'hFFFFFFF0);
    run_load("lbu", OP_LBU, 32'h103, 32'h000000F0, 32'h000000F0);
    run_load("lb0", OP_LB, 32'h100, 32'h7F000080, 32'h0000007F);
    run_load("lh2", OP_LH, 32'h102, 32'h12348001, 32'hFFFF8001);
    run_load("lhu0", OP_LHU, 32'h100, 32'hABCD1234, 32'h0000ABCD);

    // SH 0x202: low half-word lanes, data replicated, no writeback.
    apply_stimulus(OP_SH, 32'h202, 32'h0000ABCD, 5'd4, 1'b1);
    #1;
    check_output("sh_stall", {31'b0, stall_req}, 32'd1);
    tick();
    d_ack = 1'b1;
    #1;
    check_output("sh_daddr", d_addr, 32'h200);
    check_output("sh_dsel", {28'b0, d_sel}, 32'h3);
    check_output("sh_dwe", {31'b0, d_we}, 32'd1);
    check_output("sh_dwdata", d_wdata, 32'hABCDABCD);
    tick();
    d_ack = 1'b0;
    #1;
    check_output("sh_wreg", {31'b0, wb_wreg}, 32'd0);
    check_output("sh_done_stall", {31'b0, stall_req}, 32'd0);
    tick();

    // SB 0x201: single lane, byte replicated.
    apply_stimulus(OP_SB, 32'h201, 32'h1234565A, 5'd4, 1'b1);
    tick();
    d_ack = 1'b1;
    #1;
    check_output("sb_dsel", {28'b0, d_sel}, 32'h4);
    check_output("sb_dwdata", d_wdata, 32'h5A5A5A5A);
    tick();
    d_ack = 1'b0;
    tick();
    apply_stimulus(OP_NOP, 32'h0, 32'h0, 5'd0, 1'b0);

    // Misaligned LW: flag for one cycle, no bus cycle, no stall.
    apply_stimulus(OP_LW, 32'h101, 32'h0, 5'd6, 1'b1);
    #1;
    check_output("mis_exc", {31'b0, exc_align}, 32'd1);
    check_output("mis_stall", {31'b0, stall_req}, 32'd0);
    check_output("mis_wreg", {31'b0, wb_wreg}, 32'd0);
    tick();
    apply_stimulus(OP_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
    #1;
    check_output("mis_dreq", {31'b0, d_req}, 32'd0);
    check_output("mis_exc_clr", {31'b0, exc_align}, 32'd0);
    tick();

    // No d_ack: request held 4 BUS cycles, then abort with exc_bus.
    apply_stimulus(OP_LW, 32'h300, 32'h0, 5'd8, 1'b1);
    tick();
    for (int i = 0; i < 4; i++) begin
      #1;
      check_output($sformatf("to_dreq%0d", i), {31'b0, d_req}, 32'd1);
      check_output($sformatf("to_exc%0d", i), {31'b0, exc_bus}, 32'd0);
      tick();
    end
    #1;
    check_output("to_dreq_drop", {31'b0, d_req}, 32'd0);
    check_output("to_exc_bus", {31'b0, exc_bus}, 32'd1);
    check_output("to_wreg", {31'b0, wb_wreg}, 32'd0);
    check_output("to_stall", {31'b0, stall_req}, 32'd0);
    tick();
    apply_stimulus(OP_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
    #1;
    check_output("to_exc_clr", {31'b0, exc_bus}, 32'd0);
    tick();

    // Reset in the second BUS cycle abandons the transfer.
    apply_stimulus(OP_LW, 32'h400, 32'h0, 5'd10, 1'b1);
    tick();
    tick();
    rst = 1'b1;
    #1;
    check_output("rb_in_rst_wreg", {31'b0, wb_wreg}, 32'd0);
    check_output("rb_in_rst_stall", {31'b0, stall_req}, 32'd0);
    tick();
    rst = 1'b0;
    apply_stimulus(OP_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
    d_ack   = 1'b1;
    d_rdata = 32'hCAFEF00D;
    #1;
    check_output("rb_dreq", {31'b0, d_req}, 32'd0);
    check_output("rb_stall", {31'b0, stall_req}, 32'd0);
    tick();
    d_ack = 1'b0;
    #1;
    check_output("rb_dreq2", {31'b0, d_req}, 32'd0);
    check_output("rb_wdata", wb_wdata, 32'h0);
    tick();

    run_load("post_rst_lw", OP_LW, 32'h500, 32'h89ABCDEF, 32'h89ABCDEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
